// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants and types for the IF-stage fetch controller.
package if_fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1c000000;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_inst_buf.sv
// Holds a returned instruction while the ID stage is stalled.
module if_inst_buf
  import if_fetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic            clr_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      data_q <= '0;
    end else if (we_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: one outstanding SRAM-like request, redirect
// handling with cancel of in-flight data, and a valid/allowin handoff to ID.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        excep_flush_i,
  input  logic [31:0] excep_pc_i,
  input  logic        branch_flush_i,
  input  logic [31:0] branch_pc_i,
  input  logic        next_allowin_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        to_next_valid_o,
  output logic [31:0] to_next_pc_o,
  output logic [31:0] to_next_inst_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            cancel_q, cancel_d;
  logic            buf_we, buf_clr;
  logic [XLEN-1:0] buf_q;

  logic            flush;
  logic [XLEN-1:0] flush_target;
  logic            valid;
  logic            handoff;

  assign flush        = excep_flush_i | branch_flush_i;
  assign flush_target = excep_flush_i ? excep_pc_i : branch_pc_i;

  assign valid = ((state_q == ST_WAIT && inst_data_ok_i && !cancel_q) ||
                  (state_q == ST_HOLD)) && !flush && !rst;
  assign handoff = valid && next_allowin_i;

  assign inst_req_o      = (state_q == ST_REQ) && !rst;
  assign inst_addr_o     = pc_q;
  assign to_next_valid_o = valid;
  assign to_next_pc_o    = pc_q;
  assign to_next_inst_o  = (state_q == ST_HOLD) ? buf_q : inst_rdata_i;

  // Next-state: a flush always retargets pc; whether a request is left
  // in flight decides between REQ and WAIT-with-cancel.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cancel_d = cancel_q;
    buf_we   = 1'b0;
    buf_clr  = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (flush) begin
          pc_d = flush_target;
          if (inst_addr_ok_i) begin
            state_d  = ST_WAIT;
            cancel_d = 1'b1;
          end
        end else if (inst_addr_ok_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          pc_d = flush_target;
          if (inst_data_ok_i) begin
            state_d  = ST_REQ;
            cancel_d = 1'b0;
          end else begin
            cancel_d = 1'b1;
          end
        end else if (inst_data_ok_i) begin
          if (cancel_q) begin
            state_d  = ST_REQ;
            cancel_d = 1'b0;
          end else if (next_allowin_i) begin
            state_d = ST_REQ;
            pc_d    = pc_q + PC_INCR;
          end else begin
            state_d = ST_HOLD;
            buf_we  = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (flush) begin
          state_d = ST_REQ;
          pc_d    = flush_target;
          buf_clr = 1'b1;
        end else if (handoff) begin
          state_d = ST_REQ;
          pc_d    = pc_q + PC_INCR;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cancel_q <= cancel_d;
    end
  end

  if_inst_buf u_inst_buf (
    .clk   (clk),
    .rst   (rst),
    .we_i  (buf_we),
    .clr_i (buf_clr),
    .d_i   (inst_rdata_i),
    .q_o   (buf_q)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        excep_flush_i, branch_flush_i, next_allowin_i;
  logic [31:0] excep_pc_i, branch_pc_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i, inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        to_next_valid_o;
  logic [31:0] to_next_pc_o, to_next_inst_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .excep_flush_i   (excep_flush_i),
    .excep_pc_i      (excep_pc_i),
    .branch_flush_i  (branch_flush_i),
    .branch_pc_i     (branch_pc_i),
    .next_allowin_i  (next_allowin_i),
    .inst_req_o      (inst_req_o),
    .inst_addr_o     (inst_addr_o),
    .inst_addr_ok_i  (inst_addr_ok_i),
    .inst_data_ok_i  (inst_data_ok_i),
    .inst_rdata_i    (inst_rdata_i),
    .to_next_valid_o (to_next_valid_o),
    .to_next_pc_o    (to_next_pc_o),
    .to_next_inst_o  (to_next_inst_o)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic idle_inputs();
    excep_flush_i  = 1'b0;
    branch_flush_i = 1'b0;
    excep_pc_i     = $urandom;
    branch_pc_i    = $urandom;
    next_allowin_i = 1'b0;
    inst_addr_ok_i = 1'b0;
    inst_data_ok_i = 1'b0;
    inst_rdata_i   = $urandom;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst            = 1'b1;
    excep_flush_i  = 1'b1;
    inst_addr_ok_i = 1'b1;
    inst_data_ok_i = 1'b1;
    next_allowin_i = 1'b1;
    mid();
    n_tests++;
    if (inst_req_o !== 1'b0 || to_next_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle: req=%b valid=%b expected 0 0", inst_req_o, to_next_valid_o);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    mid();
    n_tests++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== RST_PC || to_next_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b addr=%h valid=%b expected 1 %h 0",
               inst_req_o, inst_addr_o, to_next_valid_o, RST_PC);
    end
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    idle_inputs();
    inst_addr_ok_i = 1'b1;
    mid();
    n_tests++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h1c000000) begin
      n_fail++;
      $display("FAIL basic_req: req=%b addr=%h expected 1 1c000000", inst_req_o, inst_addr_o);
    end
    tick();
    idle_inputs();
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = 32'h02800c0c;
    next_allowin_i = 1'b1;
    mid();
    n_tests++;
    if (to_next_valid_o !== 1'b1 || to_next_pc_o !== 32'h1c000000 ||
        to_next_inst_o !== 32'h02800c0c || inst_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_valid: valid=%b pc=%h inst=%h req=%b expected 1 1c000000 02800c0c 0",
               to_next_valid_o, to_next_pc_o, to_next_inst_o, inst_req_o);
    end
    tick();
    idle_inputs();
    mid();
    n_tests++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h1c000004 || to_next_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_next: req=%b addr=%h valid=%b expected 1 1c000004 0",
               inst_req_o, inst_addr_o, to_next_valid_o);
    end
    tick();
  endtask

  task automatic test_hold();
    logic [31:0] word;
    word = $urandom;
    idle_inputs();
    inst_addr_ok_i = 1'b1;
    tick();
    idle_inputs();
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = word;
    mid();
    n_tests++;
    if (to_next_valid_o !== 1'b1 || to_next_inst_o !== word) begin
      n_fail++;
      $display("FAIL hold_arrive: valid=%b inst=%h expected 1 %h", to_next_valid_o, to_next_inst_o, word);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      mid();
      n_tests++;
      if (to_next_valid_o !== 1'b1 || to_next_inst_o !== word ||
          to_next_pc_o !== 32'h1c000004 || inst_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stall%0d: valid=%b inst=%h pc=%h req=%b expected 1 %h 1c000004 0",
                 i, to_next_valid_o, to_next_inst_o, to_next_pc_o, inst_req_o, word);
      end
      tick();
    end
    idle_inputs();
    next_allowin_i = 1'b1;
    tick();
    idle_inputs();
    mid();
    n_tests++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h1c000008 || to_next_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: req=%b addr=%h valid=%b expected 1 1c000008 0",
               inst_req_o, inst_addr_o, to_next_valid_o);
    end
    tick();
  endtask

  task automatic test_branch_cancel();
    idle_inputs();
    inst_addr_ok_i = 1'b1;
    tick();
    idle_inputs();
    branch_flush_i = 1'b1;
    branch_pc_i    = 32'h1c000100;
    tick();
    for (int i = 0; i < 2; i++) begin
      idle_inputs();
      next_allowin_i = 1'b1;
      inst_data_ok_i = (i == 1);
      mid();
      n_tests++;
      if (to_next_valid_o !== 1'b0 || inst_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL cancel_wait%0d: valid=%b req=%b expected 0 0", i, to_next_valid_o, inst_req_o);
      end
      tick();
    end
    idle_inputs();
    mid();
    n_tests++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h1c000100) begin
      n_fail++;
      $display("FAIL cancel_redirect: req=%b addr=%h expected 1 1c000100", inst_req_o, inst_addr_o);
    end
    tick();
  endtask

  task automatic test_dual_flush();
    idle_inputs();
    excep_flush_i  = 1'b1;
    excep_pc_i     = 32'h1c008000;
    branch_flush_i = 1'b1;
    branch_pc_i    = 32'h1c000100;
    tick();
    idle_inputs();
    mid();
    n_tests++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h1c008000) begin
      n_fail++;
      $display("FAIL dual_flush: req=%b addr=%h expected 1 1c008000", inst_req_o, inst_addr_o);
    end
    tick();
  endtask

  task automatic test_flush_data();
    logic [31:0] word;
    word = $urandom;
    idle_inputs();
    inst_addr_ok_i = 1'b1;
    tick();
    idle_inputs();
    inst_data_ok_i = 1'b1;
    next_allowin_i = 1'b1;
    branch_flush_i = 1'b1;
    branch_pc_i    = 32'h1c000200;
    mid();
    n_tests++;
    if (to_next_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_data_valid: valid=%b expected 0", to_next_valid_o);
    end
    tick();
    idle_inputs();
    inst_addr_ok_i = 1'b1;
    mid();
    n_tests++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h1c000200) begin
      n_fail++;
      $display("FAIL flush_data_redirect: req=%b addr=%h expected 1 1c000200", inst_req_o, inst_addr_o);
    end
    tick();
    idle_inputs();
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = word;
    next_allowin_i = 1'b1;
    mid();
    n_tests++;
    if (to_next_valid_o !== 1'b1 || to_next_pc_o !== 32'h1c000200 || to_next_inst_o !== word) begin
      n_fail++;
      $display("FAIL flush_data_nocancel: valid=%b pc=%h inst=%h expected 1 1c000200 %h",
               to_next_valid_o, to_next_pc_o, to_next_inst_o, word);
    end
    tick();
  endtask

  task automatic test_wrap();
    idle_inputs();
    excep_flush_i = 1'b1;
    excep_pc_i    = 32'hfffffffc;
    tick();
    idle_inputs();
    inst_addr_ok_i = 1'b1;
    tick();
    idle_inputs();
    inst_data_ok_i = 1'b1;
    next_allowin_i = 1'b1;
    mid();
    n_tests++;
    if (to_next_valid_o !== 1'b1 || to_next_pc_o !== 32'hfffffffc) begin
      n_fail++;
      $display("FAIL wrap_valid: valid=%b pc=%h expected 1 fffffffc", to_next_valid_o, to_next_pc_o);
    end
    tick();
    idle_inputs();
    mid();
    n_tests++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h00000000) begin
      n_fail++;
      $display("FAIL wrap_next: req=%b addr=%h expected 1 00000000", inst_req_o, inst_addr_o);
    end
    tick();
  endtask

  // Reference model tracks fetch transactions: pc, whether a request is in
  // flight, whether that request was orphaned by a redirect, and a parked word.
  task automatic test_random();
    logic [31:0] m_pc, m_held_inst, tgt;
    logic        m_pending, m_stale, m_held;
    logic        exp_req, exp_valid, flush, accepted, returned, new_pending;
    logic [31:0] exp_inst;
    int          handoffs;
    handoffs = 0;
    do_reset();
    m_pc = RST_PC; m_pending = 0; m_stale = 0; m_held = 0; m_held_inst = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      idle_inputs();
      rst            = ($urandom_range(99) == 0);
      excep_flush_i  = ($urandom_range(9) == 0);
      branch_flush_i = ($urandom_range(9) == 0);
      excep_pc_i     = {$urandom_range(32'h3fffffff), 2'b00};
      branch_pc_i    = {$urandom_range(32'h3fffffff), 2'b00};
      next_allowin_i = $urandom_range(1);
      inst_addr_ok_i = !m_pending && ($urandom_range(9) < 6);
      inst_data_ok_i = m_pending && ($urandom_range(9) < 6);
      mid();
      if (rst) begin
        n_tests++;
        if (inst_req_o !== 1'b0 || to_next_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_reset c%0d: req=%b valid=%b expected 0 0", cyc, inst_req_o, to_next_valid_o);
        end
        m_pc = RST_PC; m_pending = 0; m_stale = 0; m_held = 0;
        tick();
        continue;
      end
      flush     = excep_flush_i || branch_flush_i;
      tgt       = excep_flush_i ? excep_pc_i : branch_pc_i;
      exp_req   = !m_pending && !m_held;
      exp_valid = !flush && ((m_pending && inst_data_ok_i && !m_stale) || m_held);
      exp_inst  = m_held ? m_held_inst : inst_rdata_i;
      n_tests++;
      if (inst_req_o !== exp_req || (exp_req && inst_addr_o !== m_pc)) begin
        n_fail++;
        $display("FAIL rand_req c%0d: req=%b addr=%h expected %b %h", cyc, inst_req_o, inst_addr_o, exp_req, m_pc);
      end
      n_tests++;
      if (to_next_valid_o !== exp_valid ||
          (exp_valid && (to_next_pc_o !== m_pc || to_next_inst_o !== exp_inst))) begin
        n_fail++;
        $display("FAIL rand_valid c%0d: valid=%b pc=%h inst=%h expected %b %h %h",
                 cyc, to_next_valid_o, to_next_pc_o, to_next_inst_o, exp_valid, m_pc, exp_inst);
      end
      accepted    = exp_req && inst_addr_ok_i;
      returned    = m_pending && inst_data_ok_i;
      new_pending = (m_pending && !returned) || accepted;
      if (flush) begin
        m_pc    = tgt;
        m_held  = 0;
        m_stale = new_pending;
      end else begin
        if (exp_valid && next_allowin_i) begin
          m_pc   = m_pc + 32'd4;
          m_held = 0;
          handoffs++;
        end else if (returned && !m_stale) begin
          m_held      = 1;
          m_held_inst = inst_rdata_i;
        end
        m_stale = m_stale && !returned;
      end
      m_pending = new_pending;
      tick();
    end
    n_tests++;
    if (handoffs < 50) begin
      n_fail++;
      $display("FAIL rand_progress: handoffs=%0d expected at least 50", handoffs);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_basic();
    test_hold();
    test_branch_cancel();
    test_dual_flush();
    test_flush_data();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports excep_flush_i (in, 1) and excep_pc_i (in, 32): exception or ertn redirect request and its target.
REQ-005 SHALL have ports branch_flush_i (in, 1) and branch_pc_i (in, 32): branch redirect request and its target.
REQ-006 SHALL have port next_allowin_i, input, 1 bit: the IF-to-ID pipeline register accepts data this cycle.
REQ-007 SHALL have ports inst_req_o (out, 1) and inst_addr_o (out, 32): instruction fetch request toward the SRAM-like bridge.
REQ-008 SHALL have ports inst_addr_ok_i (in, 1), inst_data_ok_i (in, 1) and inst_rdata_i (in, 32): bridge address accept, data return and data.
REQ-009 SHALL have ports to_next_valid_o (out, 1), to_next_pc_o (out, 32) and to_next_inst_o (out, 32): the producer side of the IF-to-ID valid/allowin handshake.

Function
REQ-010 SHALL implement FSM states REQ (request asserted), WAIT (one request outstanding) and HOLD (instruction buffered, ID stalled).
REQ-011 SHALL assert inst_req_o exactly when in REQ, with inst_addr_o equal to the pc register.
REQ-012 SHALL move REQ to WAIT on inst_addr_ok_i; otherwise it SHALL stay in REQ with the address held stable.
REQ-013 SHALL have at most one request outstanding; no new request SHALL be issued before the outstanding data_ok arrives.
REQ-014 SHALL drive to_next_valid_o combinationally as ((WAIT and inst_data_ok_i and not cancel) or HOLD) and not (excep_flush_i or branch_flush_i).
REQ-015 SHALL present to_next_inst_o as inst_rdata_i in WAIT and as the buffer in HOLD; to_next_pc_o SHALL equal the pc register.
REQ-016 SHALL complete a handoff when to_next_valid_o and next_allowin_i are both high; next cycle: pc = pc + 4 (mod 2^32, wraps silently) and state = REQ.
REQ-017 SHALL latch inst_rdata_i into the 32-bit buffer and enter HOLD when valid data arrives in WAIT and next_allowin_i is low.
REQ-018 SHALL take a redirect target with excep_flush_i priority over branch_flush_i when both are high in the same cycle.
REQ-019 SHALL handle a flush in REQ without addr_ok, or in HOLD, as follows: pc = target; state = REQ; buffer discarded.
REQ-020 SHALL handle a flush in REQ with addr_ok the same cycle, or in WAIT without data_ok, as follows: pc = target; state = WAIT; cancel = 1.
REQ-021 SHALL handle a flush in WAIT with data_ok the same cycle as follows: data dropped; pc = target; state = REQ; cancel = 0.
REQ-022 SHALL, on data_ok with cancel = 1, drop the data, clear cancel, go to REQ and never show valid for it.
REQ-023 SHALL have a minimum latency of one cycle from addr_ok to valid; back-to-back fetches SHALL sustain one instruction per two cycles when the bridge answers in one cycle.

Reset
REQ-024 SHALL set on reset: state = REQ; pc = RESET_PC; cancel = 0; buffer = 0.
REQ-025 SHALL hold inst_req_o = 0 and to_next_valid_o = 0 during the reset cycle; reset SHALL override flush and all handshakes.
REQ-026 SHALL treat reset mid-transaction as a full restart, with no cancel kept for the old outstanding request (the bridge is reset together).

Structure
REQ-027 SHALL place RESET_PC default, FSM state encodings and the PC increment constant in the shared define file.
REQ-028 SHALL place the instruction buffer in one sub-module, if_inst_buf (32-bit register with we/clear); all other logic in one file.

Verification
REQ-029 SHALL cover: reset, then addr_ok at cycle 1 and data_ok with rdata 32'h02800c0c at cycle 2, next_allowin_i = 1 -> valid at cycle 2 with pc 1c000000; req at cycle 3 with address 1c000004.
REQ-030 SHALL cover: data_ok while next_allowin_i = 0 for 3 cycles -> HOLD, valid held with the same inst/pc and inst_req_o = 0; allowin rises -> handoff, next address +4.
REQ-031 SHALL cover: branch_flush_i with branch_pc_i = 1c000100 in WAIT, data_ok 2 cycles later -> no valid, then request to 1c000100.
REQ-032 SHALL cover: excep_flush_i (pc 1c008000) and branch_flush_i (pc 1c000100) in the same cycle -> next request to 1c008000.
REQ-033 SHALL cover: flush coincident with data_ok -> valid low that cycle, next-cycle request to the target, cancel = 0.
REQ-034 SHALL cover: pc = 32'hfffffffc handoff -> next address 32'h00000000.
